vehicle_sensor_conditioner: RTL
===============================

# vehicle_sensor_conditioner

Front-end stage feeding the traffic light controller's `sa`/`sb` inputs. It takes raw, asynchronous, bouncy vehicle-loop detector signals for street A and street B and synchronizes and debounces them. It latches each vehicle call until that street's green is served. It also generates the periodic step tick that paces the controller and flags detectors stuck active.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flip-flops per sensor; legal values 2 or more.
- `DEBOUNCE_CYCLES`, default 16: consecutive disagreeing samples required to change the debounced level; legal values 1 or more.
- `TICK_DIV`, default 50_000_000: clk cycles per `tick` pulse; legal values 2 or more.
- `STUCK_TICKS`, default 120: ticks of continuous debounced-high before a fault is flagged; legal values 1 or more.
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous reset, active-low.
- `raw_a`, input, 1: street A loop detector, asynchronous, active-high.
- `raw_b`, input, 1: street B loop detector, asynchronous, active-high.
- `green_a`, input, 1: controller `ga` fed back, synchronous to `clk`.
- `green_b`, input, 1: controller `gb` fed back, synchronous to `clk`.
- `sa`, output, 1: latched street A call, to the controller.
- `sb`, output, 1: latched street B call, to the controller.
- `tick`, output, 1: one-cycle step pulse, to the controller's step enable.
- `fault_a`, output, 1: street A detector stuck-high flag.
- `fault_b`, output, 1: street B detector stuck-high flag.

## Operation
- Channels A and B are identical and independent. Each has a synchronizer, a debouncer, a call latch and a stuck detector.
- Synchronizer: a `SYNC_STAGES`-deep shift register of `raw_x`. Its last stage is `sync_x`.
- Debouncer: holds a stable level `deb_x` and a counter `dcnt_x` of width clog2(`DEBOUNCE_CYCLES`+1).
  - If `sync_x == deb_x`: `dcnt_x` ← 0.
  - Else if `dcnt_x == DEBOUNCE_CYCLES-1`: `deb_x` ← `sync_x` and `dcnt_x` ← 0.
  - Else: `dcnt_x` increments.
  - Any agreeing sample restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach `deb_x`.
- Call latch: `call_x` ← `deb_x | (call_x & ~green_x)`.
  - Set dominates clear: a vehicle still present during its own green keeps the call.
  - A vehicle that leaves before its green is still remembered until served.
  - `sa = call_a` and `sb = call_b`, both registered.
- Tick generator: counter `tcnt` of width clog2(`TICK_DIV`) running 0..`TICK_DIV`-1 and wrapping to 0.
  - `tick` is a registered output, high for exactly one cycle when `tcnt == TICK_DIV-1`.
  - It is free-running and unaffected by the sensors.
- Stuck detector: counter `scnt_x` of width clog2(`STUCK_TICKS`+1).
  - While `deb_x` = 1, it increments on each `tick` and saturates at `STUCK_TICKS`.
  - When `deb_x` = 0, `scnt_x` ← 0 and `fault_x` ← 0.
  - `fault_x` ← 1 on the cycle `scnt_x` reaches `STUCK_TICKS`, and stays set until `deb_x` falls.
  - A fault does not alter `call_x`. A stuck sensor behaves as permanent demand, which is failsafe for the controller.

## Timing
- Reset (`rst` low, asynchronous):
  - All synchronizer stages, `deb_x`, `dcnt_x`, `call_x`, `tcnt`, `scnt_x` ← 0.
  - Outputs `sa`=0, `sb`=0, `tick`=0, `fault_a`=0, `fault_b`=0.
- Reset mid-operation drops pending calls and faults immediately. No state survives.
- Latency from a clean `raw_x` rising edge to `sa`/`sb` high: `SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1 cycles, ±1 cycle of sampling uncertainty.
- Falling edge of `raw_x` to `deb_x` low: `SYNC_STAGES` + `DEBOUNCE_CYCLES` cycles, ±1. `call_x` falls one cycle after `deb_x` is low and `green_x` is high.
- Clear requires `green_x` sampled high while `deb_x` is low. If `green_x` is already high when `deb_x` falls, the clear happens on the next edge.
- First `tick` after reset release: `TICK_DIV` cycles later. Thereafter it repeats with period exactly `TICK_DIV`.
- `fault_x` asserts on the `STUCK_TICKS`-th tick after `deb_x` rose. A tick on the same cycle `deb_x` rises is not counted.

## Structure
- Shared package `traffic_pkg`: default parameter constants, `TICK_DIV_DEFAULT` and `DEBOUNCE_DEFAULT`.
- One sub-module, `sensor_channel`: synchronizer, debouncer, call latch and stuck detector for one street. It takes `tick` as an input and is instantiated twice.
- The top level holds the tick generator and the two channel instances.

## Test plan
All scenarios use `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `TICK_DIV`=10, `STUCK_TICKS`=3.
- **Reset:** hold `rst` low with `raw_a`=`raw_b`=1. All outputs stay 0. Release; `tick` first pulses 10 cycles later, then every 10 cycles.
- **Glitch rejection:** pulse `raw_a` high for 3 cycles. `sa` stays 0 throughout. A 6-cycle pulse sets `sa` about 7 cycles after the rise.
- **Call latch:** pulse `raw_b` for 6 cycles with `green_b`=0. `sb` stays 1 indefinitely. Raise `green_b` for 1 cycle and `sb` drops the next cycle.
- **Set dominates:** hold `raw_a` high and `green_a`=1. `sa` stays 1. Drop `raw_a`; `sa` falls about 6–7 cycles later.
- **Stuck fault:** hold `raw_b` high for 40 cycles. `fault_b` rises at the 3rd tick after `deb_b` rises while `sb` stays 1. Drop `raw_b`; `fault_b` clears when `deb_b` falls.
- **Async reset mid-operation:** assert `rst` while `sa`=1 and `fault_a`=1. Both clear within the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared defaults for the traffic-controller front end.
// Sensor conditioning and the controller pace themselves from these constants.
package traffic_pkg;
  localparam int SYNC_DEFAULT     = 2;
  localparam int DEBOUNCE_DEFAULT = 16;
  localparam int TICK_DIV_DEFAULT = 50_000_000;
  localparam int STUCK_DEFAULT    = 120;
endpackage

// File: rtl/sensor_channel.sv
// One street's detector path: synchronizer, debouncer, call latch and stuck-high detector.
// The tick input paces the stuck counter.
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int STUCK_TICKS     = STUCK_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic green,
  input  logic tick,
  output logic call,
  output logic fault
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STUCK_TICKS + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCNT_MAX  = SW'(STUCK_TICKS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   deb;
  logic                   deb_next;
  logic [DW-1:0]          dcnt;
  logic [DW-1:0]          dcnt_next;
  logic [SW-1:0]          scnt;
  logic [SW-1:0]          scnt_next;
  logic                   fault_next;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Metastability shift register for the asynchronous loop input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Debounce: any agreeing sample restarts the disagreement run.
  always_comb begin
    deb_next  = deb;
    dcnt_next = '0;
    if (sync_lvl == deb) begin
      dcnt_next = '0;
    end else if (dcnt == DCNT_LAST) begin
      deb_next  = sync_lvl;
      dcnt_next = '0;
    end else begin
      dcnt_next = dcnt + DW'(1);
    end
  end

  // Stuck detector counts ticks only while the debounced level was already high.
  always_comb begin
    scnt_next  = scnt;
    fault_next = fault;
    if (!deb) begin
      scnt_next  = '0;
      fault_next = 1'b0;
    end else begin
      if (tick && (scnt != SCNT_MAX)) begin
        scnt_next = scnt + SW'(1);
      end else begin
        scnt_next = scnt;
      end
      fault_next = fault | (scnt_next == SCNT_MAX);
    end
  end

  // Channel state; the call latch lets a present vehicle win over its own green.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb   <= 1'b0;
      dcnt  <= '0;
      scnt  <= '0;
      fault <= 1'b0;
      call  <= 1'b0;
    end else begin
      deb   <= deb_next;
      dcnt  <= dcnt_next;
      scnt  <= scnt_next;
      fault <= fault_next;
      call  <= deb | (call & ~green);
    end
  end
endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Front end for the traffic light controller: conditions both street detectors
// and generates the free-running step tick.
module vehicle_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int TICK_DIV        = TICK_DIV_DEFAULT,
  parameter int STUCK_TICKS     = STUCK_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_b,
  input  logic green_a,
  input  logic green_b,
  output logic sa,
  output logic sb,
  output logic tick,
  output logic fault_a,
  output logic fault_b
);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tcnt;

  // Tick divider; the pulse is registered so it follows the terminal count by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (tcnt == TCNT_LAST);
      if (tcnt == TCNT_LAST) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  sensor_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_TICKS    (STUCK_TICKS)
  ) u_chan_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_a),
    .green(green_a),
    .tick (tick),
    .call (sa),
    .fault(fault_a)
  );

  sensor_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_TICKS    (STUCK_TICKS)
  ) u_chan_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_b),
    .green(green_b),
    .tick (tick),
    .call (sb),
    .fault(fault_b)
  );
endmodule
